// File: rtl/tgate_pkg.sv
// tgate_pkg
// Shared definitions for the break-before-make transmission-gate multiplexer.
//   state_e   : switch controller states (all off / dead time / one channel on)
//   MIN_DEAD  : smallest dead time the controller honours, in clk cycles
//   clampDead : raises a requested dead time to at least MIN_DEAD
package tgate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } state_e;

  localparam int MIN_DEAD = 1;

  function automatic int clampDead(input int d);
    return (d < MIN_DEAD) ? MIN_DEAD : d;
  endfunction

endpackage

// File: rtl/tgate_ch.sv
// tgate_ch
// One channel's switch bank: WIDTH nmos pass switches sharing a single gate.
// When the gate is low every bit of out_o is released (z), so several banks
// can share one output net.
//   data_i : channel data to pass through
//   gate_i : switch enable for the whole bank
//   out_o  : shared switched output net
module tgate_ch #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             gate_i,
  output wire  [WIDTH-1:0] out_o
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_sw
    nmos sw (out_o[b], data_i[b], gate_i);
  end

endmodule

// File: rtl/tgate_mux_bbm.sv
// tgate_mux_bbm
// CH-to-1 switch multiplexer with break-before-make sequencing. Changing the
// conducting channel opens every switch, waits DEAD clk edges, then closes the
// new channel's switch, so two channels are never connected together.
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset, opens all switches at once
//   en         : global enable; low at an edge opens all switches, returns to idle
//   sel_req    : requested channel index
//   sel_vld    : channel-change request valid
//   ch_in      : channel data, channel c at bits [c*WIDTH +: WIDTH]
//   dout       : switched data, released when no channel conducts
//   sel_ack    : one-cycle pulse, request accepted
//   sel_err    : one-cycle pulse, request rejected (index out of range)
//   busy       : high during dead time
//   on         : high while a channel conducts
//   active_sel : index of the conducting or pending channel
// Build option: define TGATE_PULLDOWN_EN to add a weak pull-down on every dout
// bit so dout reads 0 instead of z when no channel conducts.
module tgate_mux_bbm
  import tgate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int DEAD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [$clog2(CH)-1:0]   sel_req,
  input  logic                    sel_vld,
  input  logic [CH*WIDTH-1:0]     ch_in,
  output wire  [WIDTH-1:0]        dout,
  output logic                    sel_ack,
  output logic                    sel_err,
  output logic                    busy,
  output logic                    on,
  output logic [$clog2(CH)-1:0]   active_sel
);

  localparam int SEL_W    = $clog2(CH);
  localparam int DEAD_EFF = clampDead(DEAD);
  localparam int CNT_W    = $clog2(DEAD_EFF + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CH-1:0]      gate_q, gate_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               reqInRange;

  function automatic logic [CH-1:0] oneHot(input logic [SEL_W-1:0] idx);
    logic [CH-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      v[c] = (int'(idx) == c);
    end
    return v;
  endfunction

  assign reqInRange = (int'(sel_req) < CH);

  // Next-state logic. Switch enables are computed here and registered so the
  // gates only ever see glitch-free, one-hot (or all-zero) values. Requests are
  // ignored entirely while the dead time runs or the block is disabled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      gate_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ON: begin
          if (sel_vld) begin
            if (!reqInRange) begin
              err_d = 1'b1;
            end else begin
              ack_d = 1'b1;
              sel_d = sel_req;
              // Switching away from a conducting channel must break first.
              if (state_q == ST_ON && sel_req != sel_q) begin
                state_d = ST_DEAD;
                cnt_d   = CNT_W'(DEAD_EFF);
                gate_d  = '0;
              end else begin
                state_d = ST_ON;
                gate_d  = oneHot(sel_req);
              end
            end
          end
        end
        ST_DEAD: begin
          // The counter was loaded with the dead time at the breaking edge;
          // the edge that sees it at 1 is the last all-off edge.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_ON;
            cnt_d   = '0;
            gate_d  = oneHot(sel_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gate_d  = '0;
        end
      endcase
    end
  end

  // State register. Reset is asynchronous so the switches open immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      gate_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign sel_ack    = ack_q;
  assign sel_err    = err_q;
  assign busy       = (state_q == ST_DEAD);
  assign on         = (state_q == ST_ON);
  assign active_sel = sel_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    tgate_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .data_i (ch_in[c*WIDTH +: WIDTH]),
      .gate_i (gate_q[c]),
      .out_o  (dout)
    );
  end

`ifdef TGATE_PULLDOWN_EN
  for (genvar b = 0; b < WIDTH; b++) begin : g_pd
    pulldown (pull0) pd (dout[b]);
  end
`else
`endif

endmodule
